// File: rtl/polar_encoder_serial.sv
// Serial polar encoder: loads info bits around frozen zeros, runs the
// log2(N) butterfly stages one per cycle, then streams P bits per beat.
module polar_encoder_serial #(
    parameter int           N           = 16,
    parameter int           P           = 8,
    parameter logic [N-1:0] FROZEN_MASK = 16'h033F
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_bit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [P-1:0] out_bits,
    output logic         out_last
);

    localparam int LOGN = $clog2(N);
    localparam int NB   = N / P;
    localparam int IW   = LOGN;
    localparam int SW   = $clog2(LOGN);
    localparam int BW   = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ENC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] idx;
    logic [SW-1:0] stage;
    logic [BW-1:0] beat;
    logic [N-1:0]  x;
    logic [N-1:0]  x_enc;
    logic          frozen_here;
    logic          load_step;
    logic          load_done;
    logic          enc_done;
    logic          out_done;

    // Per-phase progress flags shared by the FSM and the datapath
    always_comb begin
        frozen_here = FROZEN_MASK[idx];
        load_step   = (state_q == LOAD) && (frozen_here || (in_valid && in_ready));
        load_done   = load_step && (idx == IW'(N - 1));
        enc_done    = (state_q == ENC) && (stage == SW'(LOGN - 1));
        out_done    = (state_q == OUT) && out_ready && (beat == BW'(NB - 1));
    end

    // One butterfly stage: pairs (lo, lo + 2^s) with bit s of lo clear
    always_comb begin
        x_enc = x;
        for (int s = 0; s < LOGN; s++) begin
            if (stage == SW'(s)) begin
                for (int j = 0; j < N / 2; j++) begin
                    x_enc[((j >> s) << (s + 1)) | (j & ((1 << s) - 1))] =
                        x[((j >> s) << (s + 1)) | (j & ((1 << s) - 1))] ^
                        x[(((j >> s) << (s + 1)) | (j & ((1 << s) - 1))) + (1 << s)];
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    if (load_done) state_d = ENC;
            ENC:     if (enc_done)  state_d = OUT;
            OUT:     if (out_done)  state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Outputs decoded from registered state only (no input feed-through)
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_bits  = '0;
        unique case (state_q)
            LOAD: in_ready = ~frozen_here;
            ENC:  ;
            OUT: begin
                out_valid = 1'b1;
                out_last  = (beat == BW'(NB - 1));
                for (int k = 0; k < P; k++) begin
                    out_bits[P-1-k] = x[int'(beat) * P + k];
                end
            end
            default: ;
        endcase
    end

    // Position / stage / beat counters and the codeword register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            stage <= '0;
            beat  <= '0;
            x     <= '0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (load_step) begin
                        x[idx] <= frozen_here ? 1'b0 : in_bit;
                        idx    <= idx + 1'b1;
                    end
                end
                ENC: begin
                    x     <= x_enc;
                    stage <= enc_done ? '0 : stage + 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        if (out_done) begin
                            beat <= '0;
                            idx  <= '0;
                            x    <= '0;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_polar_encoder_serial.sv
// Bench for polar_encoder_serial: default N=16 instance for protocol and
// timing scenarios, plus an N=64 instance swept against a subset-XOR model.
module tb_polar_encoder_serial;

    localparam int           N     = 16;
    localparam logic [15:0]  MASK  = 16'h033F;
    localparam int           N2    = 64;
    localparam logic [63:0]  MASK2 = 64'h0017_017F_177F_7FFF;

    logic       clk;
    logic       rst_n;
    logic       in_valid, in_ready, in_bit;
    logic       out_valid, out_ready, out_last;
    logic [7:0] out_bits;
    logic       in_valid2, in_ready2, in_bit2;
    logic       out_valid2, out_ready2, out_last2;
    logic [7:0] out_bits2;

    int passed;
    int total;

    polar_encoder_serial u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .out_last  (out_last)
    );

    polar_encoder_serial #(
        .N           (N2),
        .P           (8),
        .FROZEN_MASK (MASK2)
    ) u_dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_bit    (in_bit2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_bits  (out_bits2),
        .out_last  (out_last2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: x[i] = XOR of u[j] over all j whose set bits include i's
    function automatic logic [63:0] ref_encode(input int n, input logic [63:0] mask,
                                               input logic [63:0] info);
        logic [63:0] u;
        logic [63:0] xr;
        int k;
        u = '0;
        xr = '0;
        k = 0;
        for (int i = 0; i < n; i++) begin
            if (!mask[i]) begin
                u[i] = info[k];
                k++;
            end
        end
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                if ((i & j) == i) xr[i] = xr[i] ^ u[j];
        return xr;
    endfunction

    function automatic logic [7:0] beat_word(input logic [63:0] xr, input int b);
        logic [7:0] w;
        for (int k = 0; k < 8; k++) w[7-k] = xr[b*8+k];
        return w;
    endfunction

    function automatic int info_count(input int n, input logic [63:0] mask);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) if (!mask[i]) c++;
        return c;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
        in_valid2 = 1'b0; in_bit2 = 1'b0; out_ready2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drives one N=16 frame and reports what was seen; cycles counts
    // rising edges since the frame's LOAD began.
    task automatic frame16(input logic [7:0] info, input int vprob, input int stall,
                           output logic [7:0] b0, output logic [7:0] b1,
                           output logic l0, output logic l1, output int hs,
                           output int first_ov, output int proto_err,
                           output int hold_err, output int cycles);
        int pos, phase, encn, beats, stallcnt;
        logic exp_rdy;
        pos = 0; phase = 0; encn = 0; beats = 0; stallcnt = 0;
        hs = 0; first_ov = -1; proto_err = 0; hold_err = 0; cycles = 0;
        b0 = '0; b1 = '0; l0 = 1'b0; l1 = 1'b0;
        while (beats < 2 && cycles < 300) begin
            @(negedge clk);
            exp_rdy = (phase == 0) && !MASK[pos];
            if (in_ready !== exp_rdy) proto_err++;
            if (out_valid !== (phase == 2)) proto_err++;
            in_valid  = (hs < 8) && ($urandom_range(0, 99) < vprob);
            in_bit    = (hs < 8) ? info[hs] : 1'b0;
            out_ready = !(stall > 0 && beats == 0 && stallcnt < stall);
            if (out_valid === 1'b1) begin
                if (first_ov < 0) first_ov = cycles;
                if (beats == 0) begin
                    if (stallcnt > 0 && out_bits !== b0) hold_err++;
                    b0 = out_bits;
                    l0 = out_last;
                    if (!out_ready) stallcnt++;
                end else begin
                    b1 = out_bits;
                    l1 = out_last;
                end
                if (out_ready) beats++;
            end
            if (in_valid && in_ready === 1'b1) hs++;
            case (phase)
                0: if (MASK[pos] || in_valid) begin
                       if (pos == N - 1) phase = 1;
                       else pos++;
                   end
                1: begin
                       encn++;
                       if (encn == 4) phase = 2;
                   end
                default: ;
            endcase
            cycles++;
        end
        if (beats < 2) $display("FAIL frame16 timeout: beats %0d required 2", beats);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
        in_valid2 = 1'b0; in_bit2 = 1'b0; out_ready2 = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL reset in_ready: got %b required 0", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b required 0", out_valid); else passed++;
        total++; if (out_bits !== 8'h00) $display("FAIL reset out_bits: got %h required 00", out_bits); else passed++;
        total++; if (out_last !== 1'b0) $display("FAIL reset out_last: got %b required 0", out_last); else passed++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_all_ones();
        logic [7:0] b0, b1; logic l0, l1; int hs, fo, pe, he, cy;
        frame16(8'hFF, 100, 0, b0, b1, l0, l1, hs, fo, pe, he, cy);
        total++; if (b0 !== 8'h14) $display("FAIL ones beat0: got %h required 14", b0); else passed++;
        total++; if (b1 !== 8'h41) $display("FAIL ones beat1: got %h required 41", b1); else passed++;
        total++; if (l0 !== 1'b0) $display("FAIL ones last0: got %b required 0", l0); else passed++;
        total++; if (l1 !== 1'b1) $display("FAIL ones last1: got %b required 1", l1); else passed++;
        total++; if (fo != 20) $display("FAIL ones first_valid: got %0d required 20", fo); else passed++;
        total++; if (hs != 8) $display("FAIL ones handshakes: got %0d required 8", hs); else passed++;
        total++; if (pe != 0) $display("FAIL ones protocol: got %0d errors required 0", pe); else passed++;
    endtask

    task automatic test_single_bits();
        logic [7:0] b0, b1; logic l0, l1; int hs, fo, pe, he, cy;
        frame16(8'h01, 100, 0, b0, b1, l0, l1, hs, fo, pe, he, cy);
        total++; if (b0 !== 8'hAA) $display("FAIL u6 beat0: got %h required aa", b0); else passed++;
        total++; if (b1 !== 8'h00) $display("FAIL u6 beat1: got %h required 00", b1); else passed++;
        frame16(8'h80, 100, 0, b0, b1, l0, l1, hs, fo, pe, he, cy);
        total++; if (b0 !== 8'hFF) $display("FAIL u15 beat0: got %h required ff", b0); else passed++;
        total++; if (b1 !== 8'hFF) $display("FAIL u15 beat1: got %h required ff", b1); else passed++;
    endtask

    task automatic test_throttle();
        logic [7:0] b0, b1; logic l0, l1; int hs, fo, pe, he, cy;
        for (int f = 0; f < 3; f++) begin
            frame16(8'hFF, 50, 0, b0, b1, l0, l1, hs, fo, pe, he, cy);
            total++; if (b0 !== 8'h14) $display("FAIL throttle beat0: got %h required 14", b0); else passed++;
            total++; if (b1 !== 8'h41) $display("FAIL throttle beat1: got %h required 41", b1); else passed++;
            total++; if (hs != 8) $display("FAIL throttle handshakes: got %0d required 8", hs); else passed++;
            total++; if (pe != 0) $display("FAIL throttle protocol: got %0d errors required 0", pe); else passed++;
        end
    endtask

    task automatic test_random_info();
        logic [7:0] b0, b1, info; logic l0, l1; int hs, fo, pe, he, cy;
        logic [63:0] xr;
        for (int f = 0; f < 8; f++) begin
            info = 8'($urandom);
            xr = ref_encode(N, {48'b0, MASK}, {56'b0, info});
            frame16(info, 60, 0, b0, b1, l0, l1, hs, fo, pe, he, cy);
            total++; if (b0 !== beat_word(xr, 0)) $display("FAIL rand16 beat0: got %h required %h", b0, beat_word(xr, 0)); else passed++;
            total++; if (b1 !== beat_word(xr, 1)) $display("FAIL rand16 beat1: got %h required %h", b1, beat_word(xr, 1)); else passed++;
            total++; if (pe != 0) $display("FAIL rand16 protocol: got %0d errors required 0", pe); else passed++;
        end
    endtask

    task automatic test_stall();
        logic [7:0] b0, b1; logic l0, l1; int hs, fo, pe, he, cy;
        frame16(8'hFF, 100, 5, b0, b1, l0, l1, hs, fo, pe, he, cy);
        total++; if (b0 !== 8'h14) $display("FAIL stall beat0: got %h required 14", b0); else passed++;
        total++; if (b1 !== 8'h41) $display("FAIL stall beat1: got %h required 41", b1); else passed++;
        total++; if (he != 0) $display("FAIL stall hold: got %0d changes required 0", he); else passed++;
        total++; if (pe != 0) $display("FAIL stall protocol: got %0d errors required 0", pe); else passed++;
        total++; if (cy != 27) $display("FAIL stall frame_len: got %0d required 27", cy); else passed++;
        frame16(8'hFF, 100, 0, b0, b1, l0, l1, hs, fo, pe, he, cy);
        total++; if (fo != 20) $display("FAIL stall next_first_valid: got %0d required 20", fo); else passed++;
        total++; if (pe != 0) $display("FAIL stall next_protocol: got %0d errors required 0", pe); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] b0, b1, info; logic l0, l1; int hs, fo, pe, he, cy;
        logic [63:0] xr;
        for (int f = 0; f < 4; f++) begin
            info = 8'($urandom);
            xr = ref_encode(N, {48'b0, MASK}, {56'b0, info});
            frame16(info, 100, 0, b0, b1, l0, l1, hs, fo, pe, he, cy);
            total++; if (cy != 22) $display("FAIL b2b frame_len: got %0d required 22", cy); else passed++;
            total++; if (fo != 20) $display("FAIL b2b first_valid: got %0d required 20", fo); else passed++;
            total++; if (b0 !== beat_word(xr, 0)) $display("FAIL b2b beat0: got %h required %h", b0, beat_word(xr, 0)); else passed++;
            total++; if (b1 !== beat_word(xr, 1)) $display("FAIL b2b beat1: got %h required %h", b1, beat_word(xr, 1)); else passed++;
        end
    endtask

    task automatic check_after_reset(input string tag);
        logic [7:0] b0, b1; logic l0, l1; int hs, fo, pe, he, cy;
        total++; if (out_valid !== 1'b0) $display("FAIL %s out_valid: got %b required 0", tag, out_valid); else passed++;
        total++; if (out_bits !== 8'h00) $display("FAIL %s out_bits: got %h required 00", tag, out_bits); else passed++;
        total++; if (out_last !== 1'b0) $display("FAIL %s out_last: got %b required 0", tag, out_last); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL %s in_ready: got %b required 0", tag, in_ready); else passed++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        frame16(8'hFF, 100, 0, b0, b1, l0, l1, hs, fo, pe, he, cy);
        total++; if (b0 !== 8'h14) $display("FAIL %s next_beat0: got %h required 14", tag, b0); else passed++;
        total++; if (b1 !== 8'h41) $display("FAIL %s next_beat1: got %h required 41", tag, b1); else passed++;
        total++; if (fo != 20) $display("FAIL %s next_first_valid: got %0d required 20", tag, fo); else passed++;
    endtask

    task automatic test_reset_mid_enc();
        do_reset();
        in_valid = 1'b1; in_bit = 1'b1; out_ready = 1'b1;
        repeat (18) @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL enc_rst pre out_valid: got %b required 0", out_valid); else passed++;
        #1 rst_n = 1'b0;
        #1 check_after_reset("enc_rst");
    endtask

    task automatic test_reset_in_out();
        int n;
        do_reset();
        in_valid = 1'b1; in_bit = 1'b1; out_ready = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++; if (out_valid !== 1'b1) $display("FAIL out_rst pre out_valid: got %b required 1", out_valid); else passed++;
        total++; if (out_bits !== 8'h14) $display("FAIL out_rst pre out_bits: got %h required 14", out_bits); else passed++;
        #1 rst_n = 1'b0;
        #1 check_after_reset("out_rst");
    endtask

    task automatic test_sweep64();
        logic [63:0] info, xr;
        int k, hs, beats, cy;
        do_reset();
        k = info_count(N2, MASK2);
        for (int f = 0; f < 400; f++) begin
            info = {$urandom, $urandom};
            xr = ref_encode(N2, MASK2, info);
            hs = 0; beats = 0; cy = 0;
            while (beats < 8 && cy < 400) begin
                @(negedge clk);
                in_valid2  = (hs < k) && ($urandom_range(0, 99) < 90);
                in_bit2    = (hs < k) ? info[hs] : 1'b0;
                out_ready2 = ($urandom_range(0, 99) < 85);
                if (out_valid2 === 1'b1) begin
                    total++;
                    if (out_bits2 !== beat_word(xr, beats))
                        $display("FAIL sweep64 frame %0d beat %0d: got %h required %h", f, beats, out_bits2, beat_word(xr, beats));
                    else passed++;
                    total++;
                    if (out_last2 !== (beats == 7))
                        $display("FAIL sweep64 last frame %0d beat %0d: got %b required %b", f, beats, out_last2, beats == 7);
                    else passed++;
                    if (out_ready2) beats++;
                end
                if (in_valid2 && in_ready2 === 1'b1) hs++;
                cy++;
            end
            total++;
            if (beats != 8 || hs != k)
                $display("FAIL sweep64 frame %0d: beats %0d handshakes %0d required 8 and %0d", f, beats, hs, k);
            else passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_all_ones();
        test_single_bits();
        test_throttle();
        test_random_info();
        test_stall();
        test_back_to_back();
        test_reset_mid_enc();
        test_reset_in_out();
        test_sweep64();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
